// File: rtl/test_seq_pkg.sv
// Shared types and constants for the test iteration sequencer.
package test_seq_pkg;

  typedef enum logic [2:0] {IDLE, CLR, GEN, LAUNCH, WAIT, LOG, FIN} state_e;

  // Galois feedback mask for a maximal-length 16-bit sequence
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  ch;
    logic [15:0] n_pkt;
    logic        pass;
    logic        tmo;
  } iter_result_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit Galois LFSR with seed load and advance enable; a zero seed is replaced by SEED.
module galois_lfsr16
  import test_seq_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load) begin
      // an all-zero state would lock the register up
      q <= (seed == 16'h0000) ? SEED : seed;
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/test_iteration_sequencer.sv
// Runs NUM_TESTS randomized test iterations over NUM_CH stimulus channels and
// tallies pass/fail/timeout results for the run.
module test_iteration_sequencer
  import test_seq_pkg::*;
#(
  parameter int          NUM_TESTS   = 3,
  parameter int          NUM_CH      = 1,
  parameter int          PKT_W       = 9,
  parameter int          PKT_MIN     = 1,
  parameter int          PKT_MAX     = 256,
  parameter int          TIMEOUT_CYC = 4096,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  localparam int         ID_W        = $clog2(NUM_TESTS + 1),
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             seed_load_i,
  input  logic [15:0]      seed_i,
  output logic             tst_start_o,
  output logic [ID_W-1:0]  tst_id_o,
  output logic [CH_W-1:0]  tst_ch_o,
  output logic [PKT_W-1:0] n_pkt_o,
  input  logic             tst_done_i,
  input  logic             tst_pass_i,
  output logic             busy_o,
  output logic             run_done_o,
  output logic [ID_W-1:0]  pass_cnt_o,
  output logic [ID_W-1:0]  fail_cnt_o,
  output logic [ID_W-1:0]  tmo_cnt_o
);

  localparam logic [PKT_W-1:0] PKT_RANGE = PKT_W'(PKT_MAX - PKT_MIN);
  localparam logic [PKT_W-1:0] PKT_BASE  = PKT_W'(PKT_MIN);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_TESTS);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  state_e           state_reg;
  logic [TMO_W-1:0] tmo_timer_reg;
  logic [15:0]      lfsr_q;
  logic [PKT_W-1:0] cand;
  logic             lfsr_unused;

  assign cand        = lfsr_q[PKT_W-1:0];
  assign lfsr_unused = ^lfsr_q;

  galois_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load_i && (state_reg == IDLE)),
    .seed  (seed_i),
    .adv   (state_reg == GEN),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tmo_timer_reg <= '0;
      tst_start_o   <= 1'b0;
      tst_id_o      <= '0;
      tst_ch_o      <= '0;
      n_pkt_o       <= '0;
      busy_o        <= 1'b0;
      run_done_o    <= 1'b0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
      tmo_cnt_o     <= '0;
    end else begin
      tst_start_o <= 1'b0;
      run_done_o  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (run_i) begin
            busy_o    <= 1'b1;
            state_reg <= CLR;
          end
        end
        CLR: begin
          pass_cnt_o <= '0;
          fail_cnt_o <= '0;
          tmo_cnt_o  <= '0;
          tst_id_o   <= ID_W'(1);
          tst_ch_o   <= '0;
          state_reg  <= GEN;
        end
        GEN: begin
          // rejection sampling keeps the packet count uniform over the range
          if (cand <= PKT_RANGE) begin
            n_pkt_o     <= PKT_BASE + cand;
            tst_start_o <= 1'b1;
            state_reg   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_timer_reg <= '0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          // a done arriving in the expiry cycle takes precedence over the timeout
          if (tst_done_i) begin
            if (tst_pass_i) pass_cnt_o <= pass_cnt_o + ID_W'(1);
            else            fail_cnt_o <= fail_cnt_o + ID_W'(1);
            state_reg <= LOG;
          end else if (tmo_timer_reg == TMO_LAST) begin
            fail_cnt_o <= fail_cnt_o + ID_W'(1);
            tmo_cnt_o  <= tmo_cnt_o + ID_W'(1);
            state_reg  <= LOG;
          end else begin
            tmo_timer_reg <= tmo_timer_reg + TMO_W'(1);
          end
        end
        LOG: begin
          if (tst_id_o == ID_LAST) begin
            run_done_o <= 1'b1;
            state_reg  <= FIN;
          end else begin
            tst_id_o  <= tst_id_o + ID_W'(1);
            tst_ch_o  <= (tst_ch_o == CH_LAST) ? '0 : tst_ch_o + CH_W'(1);
            state_reg <= GEN;
          end
        end
        FIN: begin
          busy_o    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_iteration_sequencer.sv
// Directed bench: default instance A (random packet counts) and a 4-channel,
// 6-test, short-timeout, fixed-packet instance B driven from a vector table.
module tb_test_iteration_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic        run_a, sl_a, done_a, pass_a;
  logic [15:0] seed_a;
  logic        st_a, busy_a, rd_a;
  logic [1:0]  id_a, pc_a, fc_a, tc_a;
  logic [0:0]  ch_a;
  logic [8:0]  np_a;

  // instance B: NUM_TESTS=6, NUM_CH=4, TIMEOUT_CYC=16, n_pkt fixed at 5
  logic        run_b, sl_b, done_b, pass_b;
  logic [15:0] seed_b;
  logic        st_b, busy_b, rd_b;
  logic [2:0]  id_b, pc_b, fc_b, tc_b;
  logic [1:0]  ch_b;
  logic [2:0]  np_b;

  test_iteration_sequencer u_dut_a (
    .clk (clk), .rst_n (rst_n), .run_i (run_a), .seed_load_i (sl_a), .seed_i (seed_a),
    .tst_start_o (st_a), .tst_id_o (id_a), .tst_ch_o (ch_a), .n_pkt_o (np_a),
    .tst_done_i (done_a), .tst_pass_i (pass_a), .busy_o (busy_a), .run_done_o (rd_a),
    .pass_cnt_o (pc_a), .fail_cnt_o (fc_a), .tmo_cnt_o (tc_a)
  );

  test_iteration_sequencer #(
    .NUM_TESTS (6), .NUM_CH (4), .PKT_W (3), .PKT_MIN (5), .PKT_MAX (5), .TIMEOUT_CYC (16)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n), .run_i (run_b), .seed_load_i (sl_b), .seed_i (seed_b),
    .tst_start_o (st_b), .tst_id_o (id_b), .tst_ch_o (ch_b), .n_pkt_o (np_b),
    .tst_done_i (done_b), .tst_pass_i (pass_b), .busy_o (busy_b), .run_done_o (rd_b),
    .pass_cnt_o (pc_b), .fail_cnt_o (fc_b), .tmo_cnt_o (tc_b)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] mdl;

  typedef struct {
    int dly;   // 0: stray done in LAUNCH then timeout, 1..16: done on that WAIT cycle, 99: no done
    bit pass;
    int id;
    int ch;
    int pc;
    int fc;
    int tc;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // reference draw for instance A: accept 9-bit candidate when <= 255, n_pkt = 1 + cand
  function automatic int draw_a(output int tries);
    int c;
    tries = 0;
    for (int g = 0; g < 65536; g++) begin
      c = int'(mdl[8:0]);
      mdl = lfsr_next(mdl);
      tries++;
      if (c <= 255) return c + 1;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outputs"}, int'({st_a, id_a, ch_a, np_a, busy_a, rd_a, pc_a, fc_a, tc_a}), 0);
    chk({tag, "_b_outputs"}, int'({st_b, id_b, ch_b, np_b, busy_b, rd_b, pc_b, fc_b, tc_b}), 0);
  endtask

  task automatic wait_a_start(output int n);
    n = 0;
    while (!st_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("a_start_seen", int'(st_a), 1);
  endtask

  task automatic load_a(input logic [15:0] sd);
    @(negedge clk); sl_a = 1'b1; seed_a = sd;
    @(negedge clk); sl_a = 1'b0;
  endtask

  // one full run on A; the channel passes 10 cycles after each launch
  task automatic run_a_full(input bit do_load, input logic [15:0] sd);
    int k, n, exp_np, tries, rd;
    @(negedge clk); run_a = 1'b1; sl_a = do_load; seed_a = sd;
    @(negedge clk); run_a = 1'b0; sl_a = 1'b0;
    k = 1;
    for (int t = 1; t <= 3; t++) begin
      exp_np = draw_a(tries);
      wait_a_start(n);
      k += n;
      if (t == 1) chk("a_first_start_latency", k, 2 + tries);
      chk("a_tst_id", int'(id_a), t);
      chk("a_tst_ch", int'(ch_a), 0);
      chk("a_n_pkt", int'(np_a), exp_np);
      chk("a_n_pkt_in_range", int'(np_a >= 9'd1 && np_a <= 9'd256), 1);
      chk("a_busy_in_run", int'(busy_a), 1);
      $display("A run iter %0d: ch %0d n_pkt %0d (model %0d)", t, ch_a, np_a, exp_np);
      if (t == 2) begin sl_a = 1'b1; seed_a = 16'h5555; end
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        sl_a = 1'b0;
        if (c == 1) chk("a_start_one_cycle", int'(st_a), 0);
      end
      done_a = 1'b1; pass_a = 1'b1;
      @(negedge clk); done_a = 1'b0; pass_a = 1'b0;
      chk("a_n_pkt_stable", int'(np_a), exp_np);
    end
    rd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rd_a) rd++;
    end
    chk("a_run_done_pulses", rd, 1);
    chk("a_busy_after_run", int'(busy_a), 0);
    chk("a_pass_cnt", int'(pc_a), 3);
    chk("a_fail_cnt", int'(fc_a), 0);
    chk("a_tmo_cnt", int'(tc_a), 0);
  endtask

  initial begin
    int g, prev_tc, kmax;
    bit tmo_row;

    tbl[0] = '{dly: 10, pass: 1'b1, id: 1, ch: 0, pc: 1, fc: 0, tc: 0};
    tbl[1] = '{dly: 99, pass: 1'b0, id: 2, ch: 1, pc: 1, fc: 1, tc: 1};
    tbl[2] = '{dly: 16, pass: 1'b1, id: 3, ch: 2, pc: 2, fc: 1, tc: 1};
    tbl[3] = '{dly: 1,  pass: 1'b0, id: 4, ch: 3, pc: 2, fc: 2, tc: 1};
    tbl[4] = '{dly: 0,  pass: 1'b0, id: 5, ch: 0, pc: 2, fc: 3, tc: 2};
    tbl[5] = '{dly: 15, pass: 1'b0, id: 6, ch: 1, pc: 2, fc: 4, tc: 2};

    rst_n = 1'b0;
    run_a = 1'b0; sl_a = 1'b0; seed_a = '0; done_a = 1'b0; pass_a = 1'b0;
    run_b = 1'b0; sl_b = 1'b0; seed_b = '0; done_b = 1'b0; pass_b = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    // default run from the reset seed
    mdl = 16'hACE1;
    run_a_full(1'b0, 16'h0000);

    // table-driven run on instance B
    @(negedge clk); run_b = 1'b1;
    @(negedge clk); run_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = 0;
      while (!st_b && g < 3000) begin
        @(negedge clk);
        done_b = 1'b0; pass_b = 1'b0;
        g++;
      end
      chk("b_start_seen", int'(st_b), 1);
      if (i > 0) begin
        chk("b_pass_cnt", int'(pc_b), tbl[i-1].pc);
        chk("b_fail_cnt", int'(fc_b), tbl[i-1].fc);
        chk("b_tmo_cnt", int'(tc_b), tbl[i-1].tc);
      end
      chk("b_tst_id", int'(id_b), tbl[i].id);
      chk("b_tst_ch", int'(ch_b), tbl[i].ch);
      chk("b_n_pkt", int'(np_b), 5);
      $display("B iter %0d: id %0d ch %0d dly %0d pass %0d", i, id_b, ch_b, tbl[i].dly, tbl[i].pass);
      tmo_row = (tbl[i].dly == 0) || (tbl[i].dly == 99);
      prev_tc = (i == 0) ? 0 : tbl[i-1].tc;
      kmax = tmo_row ? 17 : tbl[i].dly;
      if (tbl[i].dly == 0) begin done_b = 1'b1; pass_b = 1'b0; end
      for (int k = 1; k <= kmax; k++) begin
        @(negedge clk);
        done_b = 1'b0; pass_b = 1'b0;
        if (k == tbl[i].dly) begin done_b = 1'b1; pass_b = tbl[i].pass; end
        if (tmo_row && k == 16) chk("b_tmo_not_before_expiry", int'(tc_b), prev_tc);
        if (tmo_row && k == 17) chk("b_tmo_at_expiry", int'(tc_b), tbl[i].tc);
      end
    end
    g = 0;
    while (!rd_b && g < 50) begin
      @(negedge clk);
      done_b = 1'b0; pass_b = 1'b0;
      g++;
    end
    chk("b_run_done_seen", int'(rd_b), 1);
    chk("b_final_pass", int'(pc_b), 2);
    chk("b_final_fail", int'(fc_b), 4);
    chk("b_final_tmo", int'(tc_b), 2);

    // seed load in the same cycle as run, a second run, then reset and reload
    mdl = 16'h1234;
    run_a_full(1'b1, 16'h1234);
    run_a_full(1'b0, 16'h0000);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    load_a(16'h1234);
    mdl = 16'h1234;
    run_a_full(1'b0, 16'h0000);
    load_a(16'h0000);
    mdl = 16'hACE1;
    run_a_full(1'b0, 16'h0000);

    // asynchronous reset during WAIT of test 2
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    wait_a_start(g);
    repeat (4) @(negedge clk);
    done_a = 1'b1; pass_a = 1'b1;
    @(negedge clk); done_a = 1'b0; pass_a = 1'b0;
    wait_a_start(g);
    chk("mid_reset_test2_id", int'(id_a), 2);
    repeat (3) @(negedge clk);
    chk("mid_reset_pass_before", int'(pc_a), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_run_reset");
    $display("async reset applied during WAIT of test 2");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    mdl = 16'hACE1;
    run_a_full(1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
